// File: rtl/pr_write_coalescer.sv
// Packs per-vertex 64-bit PageRank results into full 512-bit AXI write lines and tracks completion.
// Optional statistics counters are built only when PR_WC_STATS_EN is defined.
module pr_write_coalescer #(
  parameter int WORD_W  = 64,
  parameter int LINE_W  = 512,
  parameter int MAX_OUT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [63:0]         in_addr,
  input  logic [WORD_W-1:0]   in_data,
  input  logic                flush,
  output logic                flush_done,
  output logic [15:0]         awid_m,
  output logic [63:0]         awaddr_m,
  output logic [7:0]          awlen_m,
  output logic [2:0]          awsize_m,
  output logic                awvalid_m,
  input  logic                awready_m,
  output logic [15:0]         wid_m,
  output logic [LINE_W-1:0]   wdata_m,
  output logic [LINE_W/8-1:0] wstrb_m,
  output logic                wlast_m,
  output logic                wvalid_m,
  input  logic                wready_m,
  input  logic [15:0]         bid_m,
  input  logic [1:0]          bresp_m,
  input  logic                bvalid_m,
  output logic                bready_m,
  output logic                err,
  output logic [31:0]         stat_lines,
  output logic [31:0]         stat_partial
);

  localparam int LANES = LINE_W / WORD_W;
  localparam int LB    = $clog2(LANES);
  localparam int WB    = $clog2(WORD_W / 8);
  localparam int OFF   = $clog2(LINE_W / 8);
  localparam int TW    = 64 - OFF;
  localparam int CW    = $clog2(MAX_OUT + 1);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [TW-1:0]     tag_q, tag_d;
  logic [LINE_W-1:0] data_q, data_d;
  logic [LANES-1:0]  mask_q, mask_d;
  logic              flush_pend_q, flush_pend_d;
  logic              aw_vld_q, aw_vld_d;
  logic              w_vld_q, w_vld_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q;
  logic              flush_done_q, flush_done_d;

  logic [TW-1:0]    in_tag;
  logic [LB-1:0]    lane;
  logic [LANES-1:0] lane_bit;
  logic             hit, can_issue, blocked, accept, aw_hs, w_hs;

  // Lane order is reversed: the lowest address lands in the most significant lane.
  assign in_tag    = in_addr[63:OFF];
  assign lane      = LB'(LANES - 1) - in_addr[OFF-1:WB];
  assign lane_bit  = LANES'(1) << lane;
  assign hit       = (mask_q == '0) || ((in_tag == tag_q) && !mask_q[lane]);
  assign can_issue = cnt_q < CW'(MAX_OUT);
  assign blocked   = flush_pend_q && (mask_q != '0);
  assign in_ready  = !rst && (state_q == S_FILL) && hit && !blocked;
  assign accept    = in_valid && in_ready;
  assign aw_hs     = aw_vld_q && awready_m;
  assign w_hs      = w_vld_q && wready_m;

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    data_d       = data_q;
    mask_d       = mask_q;
    flush_pend_d = flush_pend_q;
    aw_vld_d     = aw_vld_q;
    w_vld_d      = w_vld_q;
    flush_done_d = 1'b0;
    cnt_d        = cnt_q + CW'(aw_hs) - CW'(bvalid_m);
    case (state_q)
      S_FILL: begin
        flush_pend_d = flush_pend_q | flush;
        if (accept) begin
          data_d[int'(lane)*WORD_W +: WORD_W] = in_data;
          mask_d = mask_q | lane_bit;
          tag_d  = in_tag;
        end
        if (mask_d != '0) begin
          // A line that wants to leave but has no free slot holds here with in_ready low.
          if ((mask_d == '1 || (in_valid && !in_ready) || flush_pend_d) && can_issue) begin
            state_d  = S_ISSUE;
            aw_vld_d = 1'b1;
            w_vld_d  = 1'b1;
          end
        end else if (flush_pend_d) begin
          state_d = S_DRAIN;
        end
      end
      S_ISSUE: begin
        flush_pend_d = flush_pend_q | flush;
        if (aw_hs) aw_vld_d = 1'b0;
        if (w_hs)  w_vld_d  = 1'b0;
        if ((aw_hs || !aw_vld_q) && (w_hs || !w_vld_q)) begin
          mask_d  = '0;
          data_d  = '0;
          state_d = flush_pend_d ? S_DRAIN : S_FILL;
        end
      end
      S_DRAIN: begin
        if (cnt_d == '0) begin
          flush_done_d = 1'b1;
          flush_pend_d = 1'b0;
          state_d      = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FILL;
      tag_q        <= '0;
      data_q       <= '0;
      mask_q       <= '0;
      flush_pend_q <= 1'b0;
      aw_vld_q     <= 1'b0;
      w_vld_q      <= 1'b0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      data_q       <= data_d;
      mask_q       <= mask_d;
      flush_pend_q <= flush_pend_d;
      aw_vld_q     <= aw_vld_d;
      w_vld_q      <= w_vld_d;
      cnt_q        <= cnt_d;
      err_q        <= err_q | (bvalid_m && (bresp_m != 2'b00));
      flush_done_q <= flush_done_d;
    end
  end

  always_comb begin
    wstrb_m = '0;
    for (int l = 0; l < LANES; l++) wstrb_m[l*(WORD_W/8) +: WORD_W/8] = {(WORD_W/8){mask_q[l]}};
  end

  assign awid_m     = 16'd0;
  assign awaddr_m   = {tag_q, {OFF{1'b0}}};
  assign awlen_m    = 8'd0;
  assign awsize_m   = 3'(OFF);
  assign awvalid_m  = aw_vld_q;
  assign wid_m      = 16'd0;
  assign wdata_m    = data_q;
  assign wlast_m    = 1'b1;
  assign wvalid_m   = w_vld_q;
  assign bready_m   = 1'b1;
  assign err        = err_q;
  assign flush_done = flush_done_q;

`ifdef PR_WC_STATS_EN
  logic [31:0] stat_lines_q, stat_partial_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lines_q   <= '0;
      stat_partial_q <= '0;
    end else if (aw_hs) begin
      stat_lines_q <= stat_lines_q + 32'd1;
      if (mask_q != '1) stat_partial_q <= stat_partial_q + 32'd1;
    end
  end
  assign stat_lines   = stat_lines_q;
  assign stat_partial = stat_partial_q;
`else
  assign stat_lines   = 32'd0;
  assign stat_partial = 32'd0;
`endif

  logic unused_ok;
  assign unused_ok = ^{bid_m, in_addr[WB-1:0]};

endmodule
